// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared state encoding and sizing helpers for the transmit
// frame sequencer (tx_frame_seq) and its byte shifter (tx_byte_shifter).
package tx_frame_pkg;

    // Frame sequencer states; CSUM is only reachable when TX_CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5
    } tx_state_e;

    // Number of bytes carried by an m-bit result word
    function automatic int unsigned nb_of(input int unsigned m);
        return m / 8;
    endfunction

    // Low bit index of the byte that leaves first: [7:0] or [m-1:m-8]
    function automatic int unsigned first_byte_lo(input int unsigned m, input bit lsb_first);
        return lsb_first ? 0 : m - 8;
    endfunction

endpackage

// File: rtl/tx_frame_seq_shifter.sv
// tx_byte_shifter: holds the not-yet-sent bytes of the result word and the
// byte presented to the UART. With TX_CHECKSUM_EN defined it also keeps a
// running XOR of every data byte presented, loadable as a trailing byte.
import tx_frame_pkg::*;

module tx_byte_shifter #(
    parameter int unsigned M         = 8,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
`ifdef TX_CHECKSUM_EN
    input  logic         load_csum_i,
`endif
    input  logic [M-1:0] data_i,
    output logic [7:0]   byte_o
);
    localparam int unsigned LO = first_byte_lo(M, LSB_FIRST != 0);

    // sr_q holds only the bytes still to be presented; the byte on byte_o
    // has already been removed from it, so M=8 needs no special case.
    logic [M-1:0] sr_q, sr_d;
    logic [7:0]   byte_q, byte_d;
`ifdef TX_CHECKSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    // Next-state for remaining bytes, presented byte and checksum
    always_comb begin
        sr_d   = sr_q;
        byte_d = byte_q;
`ifdef TX_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (load_i) begin
            byte_d = data_i[LO +: 8];
            sr_d   = (LSB_FIRST != 0) ? (data_i >> 8) : (data_i << 8);
`ifdef TX_CHECKSUM_EN
            csum_d = data_i[LO +: 8];
`endif
        end else if (shift_i) begin
            byte_d = sr_q[LO +: 8];
            sr_d   = (LSB_FIRST != 0) ? (sr_q >> 8) : (sr_q << 8);
`ifdef TX_CHECKSUM_EN
            csum_d = csum_q ^ sr_q[LO +: 8];
`endif
        end
`ifdef TX_CHECKSUM_EN
        else if (load_csum_i) begin
            byte_d = csum_q;
        end
`endif
    end

    // Register shift state; asynchronous reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            byte_q <= '0;
`ifdef TX_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            sr_q   <= sr_d;
            byte_q <= byte_d;
`ifdef TX_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    assign byte_o = byte_q;

endmodule

// File: rtl/tx_frame_seq.sv
// tx_frame_seq: splits an M-bit result word into M/8 bytes and feeds them to
// the UART transmitter with a TxEn/TxDone handshake, a GAP-cycle idle gap
// between bytes and a FrameDone pulse at the end of the frame.
// Optional macro TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
import tx_frame_pkg::*;

module tx_frame_seq #(
    parameter int unsigned M         = 8,
    parameter int unsigned GAP       = 10,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic         StartTx,
    input  logic [M-1:0] DataIn,
    input  logic         TxDone,
    output logic         TxEn,
    output logic [7:0]   TxByte,
    output logic         SetTransmit,
    output logic         FrameDone,
    output logic         Overrun
);
    localparam int unsigned   NB       = nb_of(M);
    localparam int unsigned   CW       = $clog2(NB + 1);
    localparam int unsigned   GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tx_en_q, tx_en_d;
    logic          set_tx_q, set_tx_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic          load, shift, advance, go_send;
`ifdef TX_CHECKSUM_EN
    logic          csum_ph_q, csum_ph_d;
    logic          load_csum;
`endif

    // Sequencer next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        tx_en_d      = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        load         = 1'b0;
        shift        = 1'b0;
        advance      = 1'b0;
        go_send      = 1'b0;
`ifdef TX_CHECKSUM_EN
        csum_ph_d    = csum_ph_q;
        load_csum    = 1'b0;
`endif
        if (StartTx && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (StartTx) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                    tx_en_d = 1'b1;
`ifdef TX_CHECKSUM_EN
                    csum_ph_d = 1'b0;
`endif
                end
            end
            ST_SEND, ST_CSUM: state_d = ST_WAIT;
            ST_WAIT: begin
                if (TxDone) begin
`ifdef TX_CHECKSUM_EN
                    if (csum_ph_q) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        load_csum = 1'b1;
                        csum_ph_d = 1'b1;
                        advance   = 1'b1;
                    end
`else
                    if (cnt_q == CNT_LAST) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end
`endif
                    else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift   = 1'b1;
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    go_send = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Leaving WAIT for another byte: through GAP, or straight to launch
        if (advance) begin
            if (GAP > 0) begin
                state_d = ST_GAP;
                gap_d   = '0;
            end else begin
                go_send = 1'b1;
            end
        end
        // Launch the next byte; TxEn is registered alongside the state
        if (go_send) begin
            tx_en_d = 1'b1;
`ifdef TX_CHECKSUM_EN
            state_d = csum_ph_d ? ST_CSUM : ST_SEND;
`else
            state_d = ST_SEND;
`endif
        end
        set_tx_d = (state_d != ST_IDLE);
    end

    // State, counters and Moore outputs; Rst abandons any frame at once
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            tx_en_q      <= 1'b0;
            set_tx_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef TX_CHECKSUM_EN
            csum_ph_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            tx_en_q      <= tx_en_d;
            set_tx_q     <= set_tx_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef TX_CHECKSUM_EN
            csum_ph_q    <= csum_ph_d;
`endif
        end
    end

    tx_byte_shifter #(
        .M         (M),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk         (clk),
        .rst         (Rst),
        .load_i      (load),
        .shift_i     (shift),
`ifdef TX_CHECKSUM_EN
        .load_csum_i (load_csum),
`endif
        .data_i      (DataIn),
        .byte_o      (TxByte)
    );

    assign TxEn        = tx_en_q;
    assign SetTransmit = set_tx_q;
    assign FrameDone   = frame_done_q;
    assign Overrun     = overrun_q;

endmodule
